// File: rtl/rvfi_pc_fwd_window_check_pkg.sv
// Shared types and helpers for the RVFI PC-forward window checker.
package rvfi_pc_fwd_pkg;

  localparam int unsigned ORDER_W = 64;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone,
    StFail
  } state_e;

  typedef enum logic [1:0] {
    CauseNone           = 2'd0,
    CausePcMismatch     = 2'd1,
    CauseDupOrder       = 2'd2,
    CauseRollbackUnsupp = 2'd3
  } fail_cause_e;

  // Address equality ignoring the bits below align.
  function automatic logic addr_eq(input logic [ORDER_W-1:0] a, input logic [ORDER_W-1:0] b,
                                   input int unsigned align);
    logic [ORDER_W-1:0] mask;
    mask = {ORDER_W{1'b1}} << align;
    return (a & mask) == (b & mask);
  endfunction

endpackage

// File: rtl/rvfi_pc_fwd_window_check_if.sv
// RVFI retire/rollback bus as seen by the PC-forward checker.
interface rvfi_pc_fwd_window_check_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NRET = 2
);
  logic [NRET-1:0]                          rvfi_valid;
  logic [rvfi_pc_fwd_pkg::ORDER_W*NRET-1:0] rvfi_order;
  logic [XLEN*NRET-1:0]                     rvfi_pc_rdata;
  logic [XLEN*NRET-1:0]                     rvfi_pc_wdata;
  logic                                     rvfi_rollback_valid;
  logic [rvfi_pc_fwd_pkg::ORDER_W-1:0]      rvfi_rollback_order;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_pc_wdata,
    output rvfi_rollback_valid, rvfi_rollback_order
  );

  modport slave (
    input rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_pc_wdata,
    input rvfi_rollback_valid, rvfi_rollback_order
  );
endinterface

// File: rtl/rvfi_pc_fwd_window_check_slot.sv
// One window slot: expected PC from the predecessor, pending rdata if this order retired
// first, and the checked flag. Flags a PC mismatch or a duplicate retirement.
module rvfi_pc_fwd_slot import rvfi_pc_fwd_pkg::*; #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALIGN_LSB = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            rb_clr_i,
  input  logic            rb_exp_clr_i,
  input  logic            no_pred_i,
  input  logic            pred_ret_i,
  input  logic [XLEN-1:0] pred_pc_i,
  input  logic            self_ret_i,
  input  logic            self_multi_i,
  input  logic [XLEN-1:0] self_pc_i,
  output logic            checked_d_o,
  output logic            mismatch_o,
  output logic            dup_o
);

  logic [XLEN-1:0] exp_pc_q, exp_pc_d, pend_pc_q, pend_pc_d;
  logic            exp_valid_q, exp_valid_d, pend_valid_q, pend_valid_d, checked_q, checked_d;
  logic            exp_v, pend_v, chk_v, cur_exp_v, cur_rd_v;
  logic [XLEN-1:0] cur_exp, cur_rd;

  // Next state: rollback view first, then this cycle's retirements on top of it.
  always_comb begin
    exp_v        = exp_valid_q & ~rb_exp_clr_i;
    pend_v       = pend_valid_q & ~rb_clr_i;
    chk_v        = checked_q & ~rb_clr_i;
    cur_exp_v    = pred_ret_i | exp_v;
    cur_exp      = pred_ret_i ? pred_pc_i : exp_pc_q;
    cur_rd_v     = self_ret_i | pend_v;
    cur_rd       = self_ret_i ? self_pc_i : pend_pc_q;
    exp_pc_d     = exp_pc_q;
    exp_valid_d  = exp_v;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_v;
    checked_d    = chk_v;
    mismatch_o   = 1'b0;
    dup_o        = 1'b0;
    if (en_i) begin
      dup_o = self_ret_i & (self_multi_i | chk_v | pend_v);
      if (pred_ret_i) begin
        exp_pc_d    = pred_pc_i;
        exp_valid_d = 1'b1;
      end
      if (!chk_v && cur_rd_v) begin
        if (no_pred_i || cur_exp_v) begin
          checked_d    = 1'b1;
          pend_valid_d = 1'b0;
          mismatch_o   = !no_pred_i &&
                         !addr_eq(ORDER_W'(cur_rd), ORDER_W'(cur_exp), ALIGN_LSB);
        end else begin
          pend_valid_d = 1'b1;
          pend_pc_d    = cur_rd;
        end
      end
    end
    if (clr_i) begin
      exp_pc_d     = '0;
      exp_valid_d  = 1'b0;
      pend_pc_d    = '0;
      pend_valid_d = 1'b0;
      checked_d    = 1'b0;
    end
  end

  assign checked_d_o = checked_d;

  // Slot state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      exp_pc_q     <= '0;
      exp_valid_q  <= 1'b0;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      checked_q    <= 1'b0;
    end else begin
      exp_pc_q     <= exp_pc_d;
      exp_valid_q  <= exp_valid_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      checked_q    <= checked_d;
    end
  end

endmodule

// File: rtl/rvfi_pc_fwd_window_check.sv
// PC-forward checker over a window of DEPTH consecutive RVFI orders.
// Optional: define RVFI_PC_FWD_ROLLBACK_EN to honour rollbacks instead of failing on them.
module rvfi_pc_fwd_window_check import rvfi_pc_fwd_pkg::*; #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NRET      = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ALIGN_LSB = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             arm,
  input  logic [ORDER_W-1:0]               base_order,
  rvfi_pc_fwd_window_check_if.slave        rvfi,
  output logic                             busy,
  output logic                             done,
  output logic                             fail,
  output logic [1:0]                       fail_cause,
  output logic [ORDER_W-1:0]               fail_order,
  output logic [$clog2(DEPTH+1)-1:0]       checked_cnt
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  state_e              state_q, state_d;
  fail_cause_e         fail_cause_q, fail_cause_d, err_cause;
  logic [ORDER_W-1:0]  base_q, base_d, fail_order_q, fail_order_d, err_order;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                busy_q, done_q, fail_q, err, rb_act, slot_en;
  logic [DEPTH-1:0]    self_ret, self_multi, pred_ret, no_pred, rb_clr, rb_exp_clr;
  logic [DEPTH-1:0]    checked_d, mismatch, dup;
  logic [XLEN-1:0]     self_pc [DEPTH];
  logic [XLEN-1:0]     pred_pc [DEPTH];

  assign slot_en = (state_q == StActive) && !arm;
  assign rb_act  = slot_en && rvfi.rvfi_rollback_valid;

  // Channel decode: which channels retire each slot's order or its predecessor.
  always_comb begin
    logic [ORDER_W-1:0] slot_ord;
    logic [NRET-1:0]    hits;
    slot_ord   = '0;
    hits       = '0;
    self_ret   = '0;
    self_multi = '0;
    pred_ret   = '0;
    no_pred    = '0;
    rb_clr     = '0;
    rb_exp_clr = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot_ord   = base_q + ORDER_W'(k);
      hits       = '0;
      self_pc[k] = '0;
      pred_pc[k] = '0;
      // Descending scan so the lowest channel's data wins on duplicates.
      for (int c = NRET - 1; c >= 0; c--) begin
        if (rvfi.rvfi_valid[c] && rvfi.rvfi_order[c*ORDER_W +: ORDER_W] == slot_ord) begin
          hits[c]    = 1'b1;
          self_pc[k] = rvfi.rvfi_pc_rdata[c*XLEN +: XLEN];
        end
        if (rvfi.rvfi_valid[c] &&
            rvfi.rvfi_order[c*ORDER_W +: ORDER_W] == slot_ord - ORDER_W'(1)) begin
          pred_ret[k] = 1'b1;
          pred_pc[k]  = rvfi.rvfi_pc_wdata[c*XLEN +: XLEN];
        end
      end
      self_ret[k]   = |hits;
      self_multi[k] = (hits & (hits - NRET'(1))) != '0;
      no_pred[k]    = (k == 0) && (base_q == '0);
`ifdef RVFI_PC_FWD_ROLLBACK_EN
      // The slot at rollback_order keeps its expectation: its predecessor was not squashed.
      rb_clr[k]     = rb_act && (slot_ord >= rvfi.rvfi_rollback_order);
      rb_exp_clr[k] = rb_act && (slot_ord > rvfi.rvfi_rollback_order);
`endif
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    rvfi_pc_fwd_slot #(
      .XLEN      (XLEN),
      .ALIGN_LSB (ALIGN_LSB)
    ) u_slot (
      .clock        (clock),
      .reset        (reset),
      .clr_i        (arm),
      .en_i         (slot_en),
      .rb_clr_i     (rb_clr[k]),
      .rb_exp_clr_i (rb_exp_clr[k]),
      .no_pred_i    (no_pred[k]),
      .pred_ret_i   (pred_ret[k]),
      .pred_pc_i    (pred_pc[k]),
      .self_ret_i   (self_ret[k]),
      .self_multi_i (self_multi[k]),
      .self_pc_i    (self_pc[k]),
      .checked_d_o  (checked_d[k]),
      .mismatch_o   (mismatch[k]),
      .dup_o        (dup[k])
    );
  end

  // Error arbitration: lowest order wins, mismatch over dup over rollback.
  always_comb begin
    err       = 1'b0;
    err_cause = CauseNone;
    err_order = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (mismatch[k]) begin
        err       = 1'b1;
        err_cause = CausePcMismatch;
        err_order = base_q + ORDER_W'(k);
      end else if (dup[k]) begin
        err       = 1'b1;
        err_cause = CauseDupOrder;
        err_order = base_q + ORDER_W'(k);
      end
    end
`ifndef RVFI_PC_FWD_ROLLBACK_EN
    if (rb_act && (!err || rvfi.rvfi_rollback_order < err_order)) begin
      err       = 1'b1;
      err_cause = CauseRollbackUnsupp;
      err_order = rvfi.rvfi_rollback_order;
    end
`endif
  end

  // FSM next state and registered outputs.
  always_comb begin
    cnt_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_d = cnt_d + CntW'(checked_d[k]);
    end
    state_d      = state_q;
    base_d       = base_q;
    fail_cause_d = fail_cause_q;
    fail_order_d = fail_order_q;
    if (arm) begin
      state_d      = StActive;
      base_d       = base_order;
      fail_cause_d = CauseNone;
      fail_order_d = '0;
    end else if (state_q == StActive) begin
      if (err) begin
        state_d      = StFail;
        fail_cause_d = err_cause;
        fail_order_d = err_order;
      end else if (cnt_d == CntW'(DEPTH)) begin
        state_d = StDone;
      end
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      base_q       <= '0;
      fail_cause_q <= CauseNone;
      fail_order_q <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      fail_cause_q <= fail_cause_d;
      fail_order_q <= fail_order_d;
      cnt_q        <= cnt_d;
      busy_q       <= (state_d == StActive);
      done_q       <= (state_d == StDone);
      fail_q       <= (state_d == StFail);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign fail_cause  = fail_cause_q;
  assign fail_order  = fail_order_q;
  assign checked_cnt = cnt_q;

endmodule

// File: tb/tb_rvfi_pc_fwd_window_check.sv
// Directed bench for rvfi_pc_fwd_window_check (NRET=2, DEPTH=4, ALIGN_LSB=1).
module tb_rvfi_pc_fwd_window_check;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NRET = 2;
  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, arm;
  logic [63:0] base_order;
  logic        busy, done, fail;
  logic [1:0]  fail_cause;
  logic [63:0] fail_order;
  logic [2:0]  checked_cnt;

  int n_checks = 0;
  int n_fail = 0;

  rvfi_pc_fwd_window_check_if #(.XLEN(XLEN), .NRET(NRET)) rvfi_bus ();

  rvfi_pc_fwd_window_check #(
    .XLEN      (XLEN),
    .NRET      (NRET),
    .DEPTH     (DEPTH),
    .ALIGN_LSB (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .arm         (arm),
    .base_order  (base_order),
    .rvfi        (rvfi_bus),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .fail_cause  (fail_cause),
    .fail_order  (fail_order),
    .checked_cnt (checked_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, arm;
    logic [63:0] base;
    logic [1:0]  vld;
    logic [63:0] o0;
    logic [31:0] r0, w0;
    logic [63:0] o1;
    logic [31:0] r1, w1;
    logic        eb, ed, ef;
    logic [1:0]  ec;
    logic [63:0] eo;
    logic [2:0]  en;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic a, input logic [63:0] b,
                              input logic [1:0] vld, input logic [63:0] o0,
                              input logic [31:0] r0, input logic [31:0] w0,
                              input logic [63:0] o1, input logic [31:0] r1,
                              input logic [31:0] w1, input logic eb, input logic ed,
                              input logic ef, input logic [1:0] ec, input logic [63:0] eo,
                              input logic [2:0] en);
    vec_t v;
    v.rst = rst; v.arm = a; v.base = b; v.vld = vld;
    v.o0 = o0; v.r0 = r0; v.w0 = w0; v.o1 = o1; v.r1 = r1; v.w1 = w1;
    v.eb = eb; v.ed = ed; v.ef = ef; v.ec = ec; v.eo = eo; v.en = en;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic drive(input logic rst, input logic a, input logic [63:0] b,
                       input logic [1:0] vld, input logic [63:0] o0, input logic [31:0] r0,
                       input logic [31:0] w0, input logic [63:0] o1, input logic [31:0] r1,
                       input logic [31:0] w1, input logic rb, input logic [63:0] rbo);
    reset = rst;
    arm = a;
    base_order = b;
    rvfi_bus.rvfi_valid = vld;
    rvfi_bus.rvfi_order = {o1, o0};
    rvfi_bus.rvfi_pc_rdata = {r1, r0};
    rvfi_bus.rvfi_pc_wdata = {w1, w0};
    rvfi_bus.rvfi_rollback_valid = rb;
    rvfi_bus.rvfi_rollback_order = rbo;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic eb, input logic ed, input logic ef,
                            input logic [1:0] ec, input logic [63:0] eo, input logic [2:0] en);
    chk({tag, ".busy"}, 64'(busy), 64'(eb));
    chk({tag, ".done"}, 64'(done), 64'(ed));
    chk({tag, ".fail"}, 64'(fail), 64'(ef));
    chk({tag, ".cause"}, 64'(fail_cause), 64'(ec));
    chk({tag, ".order"}, fail_order, eo);
    chk({tag, ".cnt"}, 64'(checked_cnt), 64'(en));
  endtask

  localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    // rst arm base vld o0 r0 w0 o1 r1 w1 | busy done fail cause order cnt
    // Reset, then the in-order window at base 10; arm-cycle event must be ignored.
    tbl.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 10, 2'b01, 10, 32'hBAD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b01, 9, 0, 32'h100, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b10, 0, 0, 0, 10, 32'h100, 32'h104, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 2'b11, 11, 32'h104, 32'h108, 12, 32'h108, 32'h10C,
                     1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 2'b11, 14, 32'h0, 32'h0, 13, 32'h10C, 32'h110,
                     0, 1, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4));
    // Same-cycle pair with predecessor on ch1, mismatching successor on ch0.
    tbl.push_back(mk(0, 1, 10, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b11, 9, 0, 32'h200, 10, 32'h200, 32'h204, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 2'b11, 12, 32'h20C, 32'h210, 11, 32'h204, 32'h208,
                     0, 0, 1, 1, 12, 3));
    tbl.push_back(mk(0, 0, 0, 2'b01, 13, 32'h999, 0, 0, 0, 0, 0, 0, 1, 1, 12, 3));
    // Order 10 retired twice, two cycles apart.
    tbl.push_back(mk(0, 1, 10, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b01, 9, 0, 32'h300, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b01, 10, 32'h300, 32'h304, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 2'b10, 0, 0, 0, 10, 32'h300, 32'h304, 0, 0, 1, 2, 10, 1));
    // Successor first (pending), low PC bit ignored, then same order on both channels.
    tbl.push_back(mk(0, 1, 10, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b01, 9, 0, 32'h100, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b10, 0, 0, 0, 11, 32'h105, 32'h108, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b01, 10, 32'h101, 32'h104, 0, 0, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 2'b11, 12, 32'h108, 32'h10C, 12, 32'h108, 32'h10C,
                     0, 0, 1, 2, 12, 3));
    // base 0: slot 0 has no predecessor; order 2^64-1 must not be compared.
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b11, 0, 32'hDEAD, 32'h4, AllOnes, 32'h0, 32'h999,
                     1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 2'b11, 1, 32'h4, 32'h8, 2, 32'h8, 32'hC, 1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 2'b10, 0, 0, 0, 3, 32'hC, 32'h10, 0, 1, 0, 0, 0, 4));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].arm, tbl[i].base, tbl[i].vld, tbl[i].o0, tbl[i].r0, tbl[i].w0,
            tbl[i].o1, tbl[i].r1, tbl[i].w1, 1'b0, 64'd0);
      expect_out($sformatf("vec%0d", i), tbl[i].eb, tbl[i].ed, tbl[i].ef, tbl[i].ec,
                 tbl[i].eo, tbl[i].en);
    end

    // Rollback to order 12 once 11..13 are checked and 10 is still pending.
    drive(0, 1, 10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 2'b01, 10, 32'h100, 32'h104, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 2'b11, 11, 32'h104, 32'h108, 12, 32'h108, 32'h10C, 0, 0);
    drive(0, 0, 0, 2'b01, 13, 32'h10C, 32'h110, 0, 0, 0, 0, 0);
    expect_out("rb_pre", 1, 0, 0, 0, 0, 3);
`ifdef RVFI_PC_FWD_ROLLBACK_EN
    // Re-retirement of 12 in the rollback cycle is not a duplicate.
    drive(0, 0, 0, 2'b10, 0, 0, 0, 12, 32'h108, 32'h10C, 1, 12);
    expect_out("rb_apply", 1, 0, 0, 0, 0, 2);
    drive(0, 0, 0, 2'b01, 13, 32'h10C, 32'h110, 0, 0, 0, 0, 0);
    expect_out("rb_redo13", 1, 0, 0, 0, 0, 3);
    drive(0, 0, 0, 2'b10, 0, 0, 0, 9, 32'h0, 32'h100, 0, 0);
    expect_out("rb_done", 0, 1, 0, 0, 0, 4);
`else
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 12);
    expect_out("rb_unsupp", 0, 0, 1, 3, 12, 3);
`endif

    // Reset in the middle of a window; IDLE then ignores retirements and rollbacks.
    drive(0, 1, 10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 2'b01, 9, 0, 32'h100, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 2'b11, 10, 32'h100, 32'h104, 11, 32'h104, 32'h108, 0, 0);
    expect_out("mid_pre", 1, 0, 0, 0, 0, 2);
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("mid_rst", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 2'b01, 12, 32'h108, 32'h10C, 0, 0, 0, 1, 12);
    expect_out("idle_ign", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
